// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one limb multiplier among requesters
// Grants one job at a time, drives the multiplier, returns the product or a timeout error.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_BITS  = 130,
  parameter int B_BITS  = 128,
  parameter int P_BITS  = 258,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*A_BITS-1:0]   req_a,
  input  logic [NUM_REQ*B_BITS-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [P_BITS-1:0]           rsp_product,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        mul_start,
  output logic [A_BITS-1:0]           mul_a,
  output logic [B_BITS-1:0]           mul_b,
  input  logic                        mul_busy,
  input  logic                        mul_done,
  input  logic [P_BITS-1:0]           mul_product
);
  localparam int          PTR_W   = $clog2(NUM_REQ);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [15:0]         wd_cnt_q, wd_cnt_d;
  logic [A_BITS-1:0]   a_q, a_d;
  logic [B_BITS-1:0]   b_q, b_d;
  logic [P_BITS-1:0]   prod_q, prod_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic                win_found;
  logic [PTR_W-1:0]    win_idx, cand, rr_next;
  logic [A_BITS-1:0]   win_a;
  logic [B_BITS-1:0]   win_b;
  logic [NUM_REQ-1:0]  owner_oh;

  // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_a = req_a[i*A_BITS +: A_BITS];
        win_b = req_b[i*B_BITS +: B_BITS];
      end
    end
  end

  assign rr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    owner_oh           = '0;
    owner_oh[owner_q]  = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    wd_cnt_d    = wd_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    prod_d      = prod_q;
    err_d       = err_q;
    rsp_valid_d = '0;
    req_ready   = '0;
    mul_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          a_d      = win_a;
          b_d      = win_b;
          owner_d  = win_idx;
          rr_ptr_d = rr_next;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        if (!mul_busy) begin
          wd_cnt_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done arriving on the final watchdog cycle still delivers a real product.
        if (mul_done) begin
          prod_d      = mul_product;
          err_d       = 1'b0;
          rsp_valid_d = owner_oh;
          state_d     = S_RESP;
        end else if (wd_cnt_q == WD_LAST) begin
          prod_d      = '0;
          err_d       = 1'b1;
          rsp_valid_d = owner_oh;
          state_d     = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      wd_cnt_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      wd_cnt_q    <= wd_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = prod_q;
  assign rsp_err     = err_q;
  assign busy        = (state_q != S_IDLE);
  assign mul_a       = a_q;
  assign mul_b       = b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter
// Behavioural multiplier plus a round-robin job-order reference model.
module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int AW = 130;
  localparam int BW = 128;
  localparam int PW = 258;
  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [PW-1:0]     rsp_product;
  logic              rsp_err, busy, mul_start;
  logic [AW-1:0]     mul_a;
  logic [BW-1:0]     mul_b;
  logic              mul_busy, mul_done;
  logic [PW-1:0]     mul_product;

  logic [AW-1:0]     ra [N];
  logic [BW-1:0]     rb [N];
  logic              rv [N];

  for (genvar g = 0; g < N; g++) begin : g_map
    assign req_a[g*AW +: AW] = ra[g];
    assign req_b[g*BW +: BW] = rb[g];
    assign req_valid[g]      = rv[g];
  end

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N), .A_BITS(AW), .B_BITS(BW), .P_BITS(PW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_product(mul_product)
  );

  // Multiplier model: accepts a start while not busy, pulses done lat cycles later.
  int            lat = 2;
  bit            mul_en = 1'b1;
  int            mcnt;
  int            start_edges = 0;
  logic [PW-1:0] mpend;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt        <= 0;
      mul_done    <= 1'b0;
      mul_product <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start) start_edges <= start_edges + 1;
      if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          mul_done    <= 1'b1;
          mul_product <= mpend;
        end
      end else if (mul_start && !mul_busy && mul_en) begin
        mcnt  <= lat;
        mpend <= PW'(mul_a) * PW'(mul_b);
      end
    end
  end

  typedef struct { int r; logic [AW-1:0] a; logic [BW-1:0] b; } job_t;
  job_t          jobs[$];
  int            glog[$];
  logic [N-1:0]  rv_log[$];
  logic [PW-1:0] rp_log[$];
  logic          re_log[$];
  int            m_r[$];
  logic [PW-1:0] m_p[$];
  int            m_ptr;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [AW-1:0] rnd_a();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[AW-1:0];
  endfunction

  function automatic logic [BW-1:0] rnd_b();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void add_job(int r, logic [AW-1:0] a, logic [BW-1:0] b);
    job_t j;
    j.r = r; j.a = a; j.b = b;
    jobs.push_back(j);
  endfunction

  // Reference: every queued requester stays pending, so service follows a pure rotation.
  function automatic void build_model();
    int rem[N];
    int nth[N];
    int pick, seen;
    m_r.delete(); m_p.delete();
    for (int i = 0; i < N; i++) begin rem[i] = 0; nth[i] = 0; end
    foreach (jobs[k]) rem[jobs[k].r]++;
    for (int t = 0; t < 1000; t++) begin
      pick = -1;
      for (int i = 0; i < N; i++)
        if (pick < 0 && rem[(m_ptr + i) % N] > 0) pick = (m_ptr + i) % N;
      if (pick < 0) break;
      rem[pick]--;
      seen = 0;
      foreach (jobs[k]) if (jobs[k].r == pick) begin
        if (seen == nth[pick]) m_p.push_back(PW'(jobs[k].a) * PW'(jobs[k].b));
        seen++;
      end
      nth[pick]++;
      m_r.push_back(pick);
      m_ptr = (pick + 1) % N;
    end
  endfunction

  task automatic serve(input int budget, output bit to);
    bit           drop [N];
    logic [N-1:0] g;
    int           w;
    bit           idle;
    glog.delete(); rv_log.delete(); rp_log.delete(); re_log.delete();
    for (int i = 0; i < N; i++) drop[i] = 1'b0;
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        rv_log.push_back(rsp_valid); rp_log.push_back(rsp_product); re_log.push_back(rsp_err);
      end
      for (int r = 0; r < N; r++) if (drop[r]) begin rv[r] = 1'b0; drop[r] = 1'b0; end
      for (int r = 0; r < N; r++) if (!rv[r]) begin
        for (int k = 0; k < jobs.size(); k++) if (jobs[k].r == r) begin
          ra[r] = jobs[k].a; rb[r] = jobs[k].b; rv[r] = 1'b1;
          jobs.delete(k);
          break;
        end
      end
      #1;
      g = req_ready;
      if (g != '0) begin
        w = -1;
        for (int r = 0; r < N; r++) if (g == (N'(1) << r)) w = r;
        glog.push_back(w);
        if (w >= 0) drop[w] = 1'b1;
      end
      idle = (jobs.size() == 0) && !busy && (rv_log.size() >= glog.size());
      for (int r = 0; r < N; r++) if (rv[r] || drop[r]) idle = 1'b0;
      if (idle) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mul_busy = 1'b0;
    for (int i = 0; i < N; i++) begin rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; end
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== '0 || req_ready !== '0) begin errors++;
      $display("FAIL reset_valid rsp_valid %b req_ready %b want 0", rsp_valid, req_ready); end
    checks++; if (rsp_product !== '0 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL reset_rsp product %0h err %b want 0", rsp_product, rsp_err); end
    checks++; if (busy !== 1'b0 || mul_start !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl busy %b start %b want 0", busy, mul_start); end
    checks++; if (mul_a !== '0 || mul_b !== '0) begin errors++;
      $display("FAIL reset_ops a %0h b %0h want 0", mul_a, mul_b); end
    reset_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_all_four();
    bit to;
    lat = $urandom_range(1, 4);
    for (int j = 0; j < 2; j++) for (int r = 0; r < N; r++) add_job(r, rnd_a(), rnd_b());
    build_model();
    serve(400, to);
    checks++; if (to) begin errors++; $display("FAIL all4_timeout got 1 want 0"); end
    checks++; if (glog.size() != 8 || rv_log.size() != 8) begin errors++;
      $display("FAIL all4_count grants %0d rsps %0d want 8", glog.size(), rv_log.size()); end
    for (int k = 0; k < m_r.size() && k < glog.size() && k < rv_log.size(); k++) begin
      checks++; if (glog[k] != k % N || glog[k] != m_r[k]) begin errors++;
        $display("FAIL all4_grant[%0d] got %0d want %0d", k, glog[k], m_r[k]); end
      checks++; if (rv_log[k] !== (N'(1) << m_r[k])) begin errors++;
        $display("FAIL all4_rspv[%0d] got %b want %b", k, rv_log[k], N'(1) << m_r[k]); end
      checks++; if (rp_log[k] !== m_p[k] || re_log[k] !== 1'b0) begin errors++;
        $display("FAIL all4_prod[%0d] got %0h/%b want %0h/0", k, rp_log[k], re_log[k], m_p[k]); end
    end
  endtask

  task automatic test_single();
    bit to;
    int s0;
    lat = 3;
    add_job(0, AW'(3), BW'(5));
    build_model();
    s0 = start_edges;
    serve(100, to);
    checks++; if (to || glog.size() != 1 || rv_log.size() != 1) begin errors++;
      $display("FAIL single_flow to %b grants %0d rsps %0d want 0/1/1", to, glog.size(), rv_log.size()); end
    else begin
      checks++; if (rv_log[0] !== 4'b0001) begin errors++; $display("FAIL single_rspv got %b want 0001", rv_log[0]); end
      checks++; if (rp_log[0] !== PW'(15) || re_log[0] !== 1'b0) begin errors++;
        $display("FAIL single_prod got %0d/%b want 15/0", rp_log[0], re_log[0]); end
    end
    checks++; if (mul_a !== AW'(3) || mul_b !== BW'(5)) begin errors++;
      $display("FAIL single_ops got %0d,%0d want 3,5", mul_a, mul_b); end
    checks++; if (start_edges - s0 != 1) begin errors++;
      $display("FAIL single_starts got %0d want 1", start_edges - s0); end
  endtask

  task automatic test_rr_skip();
    bit to;
    lat = $urandom_range(1, 4);
    for (int round = 0; round < 2; round++) begin
      if (round == 0) add_job(1, rnd_a(), rnd_b());
      else begin add_job(1, rnd_a(), rnd_b()); add_job(3, rnd_a(), rnd_b()); end
      build_model();
      serve(200, to);
      checks++; if (to || glog.size() != m_r.size() || rv_log.size() != m_r.size()) begin errors++;
        $display("FAIL rr_flow round %0d to %b grants %0d want %0d", round, to, glog.size(), m_r.size()); end
      for (int k = 0; k < m_r.size() && k < glog.size() && k < rv_log.size(); k++) begin
        checks++; if (glog[k] != m_r[k]) begin errors++;
          $display("FAIL rr_grant[%0d] got %0d want %0d", k, glog[k], m_r[k]); end
        checks++; if (rv_log[k] !== (N'(1) << m_r[k]) || rp_log[k] !== m_p[k]) begin errors++;
          $display("FAIL rr_rsp[%0d] got %b/%0h want %b/%0h", k, rv_log[k], rp_log[k], N'(1) << m_r[k], m_p[k]); end
      end
    end
    checks++; if (glog.size() < 1 || glog[0] != 3) begin errors++;
      $display("FAIL rr_skip_first got %0d want 3", glog.size() > 0 ? glog[0] : -1); end
  endtask

  task automatic test_max();
    bit to;
    logic [PW-1:0] expv;
    expv = PW'(0) - (PW'(1) << 130) - (PW'(1) << 128) + PW'(1);
    lat = 2;
    add_job(2, '1, '1);
    build_model();
    serve(100, to);
    checks++; if (to || rv_log.size() != 1) begin errors++;
      $display("FAIL max_flow to %b rsps %0d want 0/1", to, rv_log.size()); end
    else begin
      checks++; if (rp_log[0] !== expv || re_log[0] !== 1'b0) begin errors++;
        $display("FAIL max_prod got %0h/%b want %0h/0", rp_log[0], re_log[0], expv); end
    end
  endtask

  task automatic test_watchdog();
    bit to;
    int hi, wcnt;
    mul_en = 1'b0; mul_busy = 1'b1; hi = 0; wcnt = 0;
    @(negedge clk);
    ra[1] = rnd_a(); rb[1] = rnd_b(); rv[1] = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wd_grant got %b want 0010", req_ready); end
    @(negedge clk);
    rv[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mul_start === 1'b1) hi++;
      @(negedge clk);
    end
    checks++; if (hi != 10) begin errors++; $display("FAIL wd_start_held got %0d want 10", hi); end
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL wd_still_issue got %b want 1", mul_start); end
    mul_busy = 1'b0;
    @(negedge clk);
    checks++; if (mul_start !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL wd_wait_entry start %b busy %b want 0/1", mul_start, busy); end
    for (int c = 0; c < TO + 20; c++) begin
      if (rsp_valid !== '0) break;
      wcnt++;
      @(negedge clk);
    end
    checks++; if (wcnt != TO) begin errors++; $display("FAIL wd_cycles got %0d want %0d", wcnt, TO); end
    checks++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_product !== '0) begin errors++;
      $display("FAIL wd_rsp got %b/%b/%0h want 0010/1/0", rsp_valid, rsp_err, rsp_product); end
    @(negedge clk);
    checks++; if (rsp_valid !== '0 || rsp_err !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL wd_after got %b/%b/%b want 0000/1/0", rsp_valid, rsp_err, busy); end
    m_ptr = 2;
    mul_en = 1'b1; lat = 2;
    add_job(0, rnd_a(), rnd_b());
    build_model();
    serve(100, to);
    checks++; if (to || rv_log.size() != 1) begin errors++;
      $display("FAIL wd_next_flow to %b rsps %0d want 0/1", to, rv_log.size()); end
    else begin
      checks++; if (rv_log[0] !== 4'b0001 || rp_log[0] !== m_p[0] || re_log[0] !== 1'b0) begin errors++;
        $display("FAIL wd_next_rsp got %b/%0h/%b want 0001/%0h/0", rv_log[0], rp_log[0], re_log[0], m_p[0]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to, bad;
    lat = 30; bad = 1'b0;
    @(negedge clk);
    ra[3] = rnd_a(); rb[3] = rnd_b(); rv[3] = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rm_grant got %b want 1000", req_ready); end
    @(negedge clk);
    rv[3] = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || mul_start !== 1'b0) begin errors++;
      $display("FAIL rm_in_wait busy %b start %b want 1/0", busy, mul_start); end
    reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== '0 || rsp_product !== '0 || rsp_err !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL rm_async_rsp got %b/%0h/%b/%b want 0", rsp_valid, rsp_product, rsp_err, busy); end
    checks++; if (mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin errors++;
      $display("FAIL rm_async_mul got %b/%0h/%0h want 0", mul_start, mul_a, mul_b); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rm_no_stale got 1 want 0"); end
    lat = 2;
    add_job(2, rnd_a(), rnd_b());
    add_job(0, rnd_a(), rnd_b());
    build_model();
    serve(200, to);
    checks++; if (to || glog.size() != 2 || rv_log.size() != 2) begin errors++;
      $display("FAIL rm_flow to %b grants %0d want 0/2", to, glog.size()); end
    else begin
      checks++; if (glog[0] != 0 || glog[1] != 2) begin errors++;
        $display("FAIL rm_order got %0d,%0d want 0,2", glog[0], glog[1]); end
      checks++; if (rp_log[0] !== m_p[0] || rp_log[1] !== m_p[1]) begin errors++;
        $display("FAIL rm_prod got %0h,%0h want %0h,%0h", rp_log[0], rp_log[1], m_p[0], m_p[1]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int n;
    for (int round = 0; round < 4; round++) begin
      lat = $urandom_range(1, 5);
      for (int r = 0; r < N; r++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) add_job(r, rnd_a(), rnd_b());
      end
      if (jobs.size() == 0) add_job($urandom_range(0, N - 1), rnd_a(), rnd_b());
      build_model();
      serve(40 * m_r.size() + 50, to);
      checks++; if (to || glog.size() != m_r.size() || rv_log.size() != m_r.size()) begin errors++;
        $display("FAIL rnd_flow round %0d to %b grants %0d rsps %0d want %0d", round, to, glog.size(), rv_log.size(), m_r.size()); end
      for (int k = 0; k < m_r.size() && k < glog.size() && k < rv_log.size(); k++) begin
        checks++; if (glog[k] != m_r[k] || rv_log[k] !== (N'(1) << m_r[k])) begin errors++;
          $display("FAIL rnd_grant[%0d] got %0d/%b want %0d", k, glog[k], rv_log[k], m_r[k]); end
        checks++; if (rp_log[k] !== m_p[k] || re_log[k] !== 1'b0) begin errors++;
          $display("FAIL rnd_prod[%0d] got %0h/%b want %0h/0", k, rp_log[k], re_log[k], m_p[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_rr_skip();
    test_max();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
